// File: rtl/fifo_packet_writer.sv
// ============================================================================
// Module      : fifo_packet_writer
// Description : Frames an ingress byte stream into length-prefixed packets and
//               writes them slot by slot into fifo_memory, tracking occupancy.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_packet_writer #(
    parameter int DEPTH     = 3,
    parameter int WIDTH     = 11,
    parameter int UWIDTH    = 8,
    parameter int PTR_SZ    = 2,
    parameter int PTR_IN_SZ = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    input  logic [UWIDTH-1:0]    in_data,
    output logic                 in_ready,
    output logic                 write_en,
    output logic [PTR_SZ-1:0]    waddr,
    output logic [PTR_IN_SZ-1:0] waddr_in,
    output logic [UWIDTH-1:0]    wdata,
    output logic                 pkt_done,
    output logic [PTR_SZ-1:0]    pkt_slot,
    output logic [PTR_IN_SZ-1:0] pkt_len,
    input  logic                 slot_release,
    output logic [PTR_SZ-1:0]    count,
    output logic                 full,
    output logic                 empty,
    output logic                 len_err
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_WRITE = 1'b1
    } state_t;

    localparam logic [PTR_IN_SZ-1:0] C_MAX_LEN   = PTR_IN_SZ'(WIDTH);
    localparam logic [PTR_IN_SZ-1:0] C_ONE_LEN   = PTR_IN_SZ'(1);
    localparam logic [PTR_SZ-1:0]    C_LAST_SLOT = PTR_SZ'(DEPTH - 1);
    localparam logic [PTR_SZ-1:0]    C_FULL_CNT  = PTR_SZ'(DEPTH);

    state_t                 state_q,    state_d;
    logic [PTR_SZ-1:0]      wptr_q,     wptr_d;
    logic [PTR_IN_SZ-1:0]   idx_q,      idx_d;
    logic [PTR_IN_SZ-1:0]   len_q,      len_d;
    logic [PTR_SZ-1:0]      count_q,    count_d;
    logic                   write_en_q, write_en_d;
    logic [PTR_SZ-1:0]      waddr_q,    waddr_d;
    logic [PTR_IN_SZ-1:0]   waddr_in_q, waddr_in_d;
    logic [UWIDTH-1:0]      wdata_q,    wdata_d;
    logic                   pkt_done_q, pkt_done_d;
    logic [PTR_SZ-1:0]      pkt_slot_q, pkt_slot_d;
    logic [PTR_IN_SZ-1:0]   pkt_len_q,  pkt_len_d;
    logic                   len_err_q,  len_err_d;

    logic                   w_accept;
    logic                   w_commit;
    logic                   w_release;
    logic [PTR_IN_SZ-1:0]   w_hdr_len;
    logic [PTR_SZ-1:0]      w_wptr_next;

    assign full      = (count_q == C_FULL_CNT);
    assign empty     = (count_q == '0);
    // Only a header needs a free slot; payload bytes belong to the slot in flight.
    assign in_ready  = rst_n && ((state_q == ST_WRITE) || !full);
    assign w_accept  = in_valid && in_ready;
    assign w_hdr_len = in_data[PTR_IN_SZ-1:0];
    assign w_wptr_next = (wptr_q == C_LAST_SLOT) ? '0 : wptr_q + 1'b1;

    always_comb begin
        state_d    = state_q;
        wptr_d     = wptr_q;
        idx_d      = idx_q;
        len_d      = len_q;
        write_en_d = 1'b0;
        waddr_d    = waddr_q;
        waddr_in_d = waddr_in_q;
        wdata_d    = wdata_q;
        pkt_done_d = 1'b0;
        pkt_slot_d = pkt_slot_q;
        pkt_len_d  = pkt_len_q;
        len_err_d  = 1'b0;
        w_commit   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (w_accept) begin
                    if ((w_hdr_len == '0) || (w_hdr_len > C_MAX_LEN)) begin
                        len_err_d = 1'b1;
                    end else begin
                        write_en_d = 1'b1;
                        waddr_d    = wptr_q;
                        waddr_in_d = '0;
                        wdata_d    = in_data;
                        if (w_hdr_len == C_ONE_LEN) begin
                            w_commit  = 1'b1;
                            pkt_len_d = w_hdr_len;
                        end else begin
                            len_d   = w_hdr_len;
                            idx_d   = C_ONE_LEN;
                            state_d = ST_WRITE;
                        end
                    end
                end
            end
            ST_WRITE: begin
                if (w_accept) begin
                    write_en_d = 1'b1;
                    waddr_d    = wptr_q;
                    waddr_in_d = idx_q;
                    wdata_d    = in_data;
                    if (idx_q == (len_q - 1'b1)) begin
                        w_commit  = 1'b1;
                        pkt_len_d = len_q;
                        idx_d     = '0;
                        state_d   = ST_IDLE;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (w_commit) begin
            pkt_done_d = 1'b1;
            pkt_slot_d = wptr_q;
            wptr_d     = w_wptr_next;
        end
    end

    // A release with nothing committed is ignored; commit and release cancel.
    always_comb begin
        w_release = slot_release && (count_q != '0);
        count_d   = count_q;
        case ({w_commit, w_release})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            wptr_q     <= '0;
            idx_q      <= '0;
            len_q      <= '0;
            count_q    <= '0;
            write_en_q <= 1'b0;
            waddr_q    <= '0;
            waddr_in_q <= '0;
            wdata_q    <= '0;
            pkt_done_q <= 1'b0;
            pkt_slot_q <= '0;
            pkt_len_q  <= '0;
            len_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wptr_q     <= wptr_d;
            idx_q      <= idx_d;
            len_q      <= len_d;
            count_q    <= count_d;
            write_en_q <= write_en_d;
            waddr_q    <= waddr_d;
            waddr_in_q <= waddr_in_d;
            wdata_q    <= wdata_d;
            pkt_done_q <= pkt_done_d;
            pkt_slot_q <= pkt_slot_d;
            pkt_len_q  <= pkt_len_d;
            len_err_q  <= len_err_d;
        end
    end

    assign write_en = write_en_q;
    assign waddr    = waddr_q;
    assign waddr_in = waddr_in_q;
    assign wdata    = wdata_q;
    assign pkt_done = pkt_done_q;
    assign pkt_slot = pkt_slot_q;
    assign pkt_len  = pkt_len_q;
    assign count    = count_q;
    assign len_err  = len_err_q;

endmodule

`default_nettype wire

// File: tb/tb_fifo_packet_writer.sv
// ============================================================================
// Module      : tb_fifo_packet_writer
// Description : Scoreboard bench for fifo_packet_writer with directed packets.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fifo_packet_writer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       write_en;
    logic [1:0] waddr;
    logic [3:0] waddr_in;
    logic [7:0] wdata;
    logic       pkt_done;
    logic [1:0] pkt_slot;
    logic [3:0] pkt_len;
    logic       slot_release;
    logic [1:0] count;
    logic       full;
    logic       empty;
    logic       len_err;

    fifo_packet_writer #(
        .DEPTH(3), .WIDTH(11), .UWIDTH(8), .PTR_SZ(2), .PTR_IN_SZ(4)
    ) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .write_en(write_en), .waddr(waddr),
        .waddr_in(waddr_in), .wdata(wdata), .pkt_done(pkt_done),
        .pkt_slot(pkt_slot), .pkt_len(pkt_len), .slot_release(slot_release),
        .count(count), .full(full), .empty(empty), .len_err(len_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] slot;
        logic [3:0] idx;
        logic [7:0] data;
    } wr_t;

    typedef struct packed {
        logic [1:0] slot;
        logic [3:0] len;
    } done_t;

    wr_t   exp_wr[$];
    done_t exp_done[$];
    int    total = 0;
    int    bad = 0;
    int    len_err_seen = 0;
    wr_t   got_wr;
    done_t got_done;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a write or commit.
    always @(negedge clk) begin
        if (rst_n) begin
            if (write_en) begin
                if (exp_wr.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_write: got slot %0d idx %0d data %0h expected none",
                             waddr, waddr_in, wdata);
                end else begin
                    got_wr = exp_wr.pop_front();
                    check("wr_slot", 32'(waddr), 32'(got_wr.slot));
                    check("wr_idx", 32'(waddr_in), 32'(got_wr.idx));
                    check("wr_data", 32'(wdata), 32'(got_wr.data));
                end
            end
            if (pkt_done) begin
                if (exp_done.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_pkt_done: got slot %0d len %0d expected none",
                             pkt_slot, pkt_len);
                end else begin
                    got_done = exp_done.pop_front();
                    check("done_slot", 32'(pkt_slot), 32'(got_done.slot));
                    check("done_len", 32'(pkt_len), 32'(got_done.len));
                end
            end
            if (len_err) len_err_seen++;
        end
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_data  = b;
        while (!in_ready && n < 60) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!in_ready) begin
            total++;
            bad++;
            $display("FAIL in_ready_timeout: got in_ready 0 expected 1 for byte %0h", b);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic push_wr(input logic [1:0] s, input logic [3:0] i, input logic [7:0] d);
        exp_wr.push_back('{slot: s, idx: i, data: d});
    endtask

    // Header carries the length; payload byte i is seed+i; optional 2-cycle gap after byte 3.
    task automatic send_pkt(input logic [1:0] s, input logic [3:0] len,
                            input logic [7:0] seed, input bit gap);
        logic [7:0] b;
        for (int i = 0; i < int'(len); i++) begin
            b = (i == 0) ? {4'h0, len} : seed + 8'(i);
            if (i == int'(len) - 1) exp_done.push_back('{slot: s, len: len});
            push_wr(s, 4'(i), b);
            send_byte(b);
            if (gap && i == 3) wait_cycles(2);
        end
    endtask

    task automatic release_one();
        slot_release = 1'b1;
        @(posedge clk);
        #1;
        slot_release = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish expected finish before 100us");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n        = 1'b0;
        in_valid     = 1'b0;
        in_data      = 8'h00;
        slot_release = 1'b0;
        wait_cycles(2);

        check("rst_write_en", 32'(write_en), 0);
        check("rst_pkt_done", 32'(pkt_done), 0);
        check("rst_len_err", 32'(len_err), 0);
        check("rst_count", 32'(count), 0);
        check("rst_empty", 32'(empty), 1);
        check("rst_full", 32'(full), 0);
        check("rst_in_ready", 32'(in_ready), 0);

        @(negedge clk);
        rst_n = 1'b1;
        wait_cycles(1);
        check("idle_in_ready", 32'(in_ready), 1);

        // Single packet 03 AA BB into slot 0
        push_wr(2'd0, 4'd0, 8'h03);
        send_byte(8'h03);
        push_wr(2'd0, 4'd1, 8'hAA);
        send_byte(8'hAA);
        exp_done.push_back('{slot: 2'd0, len: 4'd3});
        push_wr(2'd0, 4'd2, 8'hBB);
        send_byte(8'hBB);
        wait_cycles(2);
        check("single_count", 32'(count), 1);
        check("single_empty", 32'(empty), 0);

        // Fill the remaining two slots
        send_pkt(2'd1, 4'd2, 8'h10, 1'b0);
        send_pkt(2'd2, 4'd2, 8'h20, 1'b0);
        wait_cycles(2);
        check("fill_count", 32'(count), 3);
        check("fill_full", 32'(full), 1);
        check("fill_in_ready", 32'(in_ready), 0);

        // Fourth header held until a release, then wraps to slot 0
        fork
            send_pkt(2'd0, 4'd2, 8'h30, 1'b0);
            begin
                repeat (4) begin
                    @(posedge clk);
                    #1;
                    check("held_write_en", 32'(write_en), 0);
                end
                check("held_in_ready", 32'(in_ready), 0);
                release_one();
            end
        join
        wait_cycles(2);
        check("wrap_count", 32'(count), 3);
        check("wrap_full", 32'(full), 1);

        // Drain, then release at empty
        release_one();
        release_one();
        release_one();
        check("drain_count", 32'(count), 0);
        check("drain_empty", 32'(empty), 1);
        release_one();
        check("release_at_empty", 32'(count), 0);

        // Illegal headers 0x00 and 0x0C
        send_byte(8'h00);
        check("len_err_zero", 32'(len_err), 1);
        send_byte(8'h0C);
        check("len_err_over", 32'(len_err), 1);
        wait_cycles(1);
        check("len_err_clear", 32'(len_err), 0);
        check("len_err_total", 32'(len_err_seen), 2);
        check("illegal_count", 32'(count), 0);

        // Next header framed normally, then a one-byte packet
        send_pkt(2'd1, 4'd2, 8'h40, 1'b0);
        send_pkt(2'd2, 4'd1, 8'h00, 1'b0);
        wait_cycles(2);
        check("pre_same_edge_count", 32'(count), 2);

        // Commit and release on the same edge
        push_wr(2'd0, 4'd0, 8'h02);
        send_byte(8'h02);
        exp_done.push_back('{slot: 2'd0, len: 4'd2});
        push_wr(2'd0, 4'd1, 8'h55);
        check("write_state_ready", 32'(in_ready), 1);
        in_valid     = 1'b1;
        in_data      = 8'h55;
        slot_release = 1'b1;
        @(posedge clk);
        #1;
        in_valid     = 1'b0;
        slot_release = 1'b0;
        wait_cycles(2);
        check("same_edge_count", 32'(count), 2);

        // Maximum legal length with a mid-packet gap
        send_pkt(2'd1, 4'd11, 8'h60, 1'b1);
        wait_cycles(2);
        check("maxlen_count", 32'(count), 3);
        release_one();
        release_one();
        release_one();
        check("drain2_count", 32'(count), 0);

        // Reset in the middle of a length-5 packet
        push_wr(2'd2, 4'd0, 8'h05);
        send_byte(8'h05);
        push_wr(2'd2, 4'd1, 8'h77);
        send_byte(8'h77);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_write_en", 32'(write_en), 0);
        check("midrst_pkt_done", 32'(pkt_done), 0);
        check("midrst_waddr", 32'(waddr), 0);
        check("midrst_waddr_in", 32'(waddr_in), 0);
        check("midrst_wdata", 32'(wdata), 0);
        check("midrst_count", 32'(count), 0);
        check("midrst_in_ready", 32'(in_ready), 0);
        check("midrst_empty", 32'(empty), 1);
        @(negedge clk);
        rst_n = 1'b1;
        wait_cycles(1);
        send_pkt(2'd0, 4'd2, 8'h80, 1'b0);
        wait_cycles(3);
        check("post_rst_count", 32'(count), 1);

        check("left_writes", 32'(exp_wr.size()), 0);
        check("left_dones", 32'(exp_done.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
